// File: rtl/rs232_fifo_periph.sv
// Memory-mapped RS-232 peripheral: RX/TX byte FIFOs, sticky error flags, level IRQ
// and a free-running timestamp counter, bridging the peripheral bus to the UART PHY.
module rs232_fifo_periph #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TSC_WIDTH     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req_a,
  input  logic        req_r,
  input  logic        req_w,
  input  logic [31:0] req_wd,
  output logic [31:0] res_rd,
  output logic        res_hold,
  input  logic        rs232in_attention,
  input  logic [7:0]  rs232in_data,
  input  logic        rs232out_busy,
  output logic        rs232out_w,
  output logic [7:0]  rs232out_d,
  output logic        irq
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0]   TX_FULL_COUNT = (TX_DEPTH_LOG2 + 1)'(TX_DEPTH);
  localparam logic [RX_DEPTH_LOG2:0]   RX_FULL_COUNT = (RX_DEPTH_LOG2 + 1)'(RX_DEPTH);
  localparam logic [TX_DEPTH_LOG2:0]   TX_CNT_ONE    = (TX_DEPTH_LOG2 + 1)'(1);
  localparam logic [RX_DEPTH_LOG2:0]   RX_CNT_ONE    = (RX_DEPTH_LOG2 + 1)'(1);
  localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE    = TX_DEPTH_LOG2'(1);
  localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE    = RX_DEPTH_LOG2'(1);
  localparam logic [TSC_WIDTH-1:0]     TSC_ONE       = TSC_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];

  logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [TX_DEPTH_LOG2:0]   tx_count_reg, tx_count_next;
  logic [RX_DEPTH_LOG2:0]   rx_count_reg, rx_count_next;
  logic [TSC_WIDTH-1:0]     tsc_reg;
  logic                     rx_overrun_reg, tx_overflow_reg;
  logic                     irq_rx_en_reg, irq_tx_en_reg;
  logic [31:0]              res_rd_reg;
  logic [7:0]               out_d_reg;
  logic                     irq_reg;
  state_t                   state_reg, state_next;

  logic [1:0]  addr;
  logic        data_rd, data_wr, ctrl_wr, sticky_clr;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        tx_overflow_set, rx_overrun_set;
  logic [31:0] status_word, rd_word;
  logic        unused_bits;

  assign addr       = req_a[3:2];
  assign data_rd    = req_r && (addr == 2'd0);
  assign data_wr    = req_w && (addr == 2'd0);
  assign ctrl_wr    = req_w && (addr == 2'd2);
  assign sticky_clr = ctrl_wr && req_wd[2];

  assign tx_empty = (tx_count_reg == '0);
  assign tx_full  = (tx_count_reg == TX_FULL_COUNT);
  assign rx_empty = (rx_count_reg == '0);
  assign rx_full  = (rx_count_reg == RX_FULL_COUNT);

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign tx_pop          = (state_reg == SEND);
  assign tx_push         = data_wr && (!tx_full || tx_pop);
  assign tx_overflow_set = data_wr && tx_full && !tx_pop;
  assign rx_pop          = data_rd && !rx_empty;
  assign rx_push         = rs232in_attention && (!rx_full || rx_pop);
  assign rx_overrun_set  = rs232in_attention && rx_full && !rx_pop;

  assign unused_bits = ^{req_a[31:4], req_a[1:0], req_wd[31:8]};

  always_comb begin
    tx_count_next = tx_count_reg;
    if (tx_push && !tx_pop)
      tx_count_next = tx_count_reg + TX_CNT_ONE;
    else if (!tx_push && tx_pop)
      tx_count_next = tx_count_reg - TX_CNT_ONE;
  end

  always_comb begin
    rx_count_next = rx_count_reg;
    if (rx_push && !rx_pop)
      rx_count_next = rx_count_reg + RX_CNT_ONE;
    else if (!rx_push && rx_pop)
      rx_count_next = rx_count_reg - RX_CNT_ONE;
  end

  always_comb begin
    status_word        = '0;
    status_word[0]     = tx_full;
    status_word[1]     = tx_empty;
    status_word[2]     = rx_empty;
    status_word[3]     = rx_full;
    status_word[4]     = rx_overrun_reg;
    status_word[5]     = tx_overflow_reg;
    status_word[15:8]  = 8'(rx_count_reg);
    status_word[23:16] = 8'(tx_count_reg);
  end

  always_comb begin
    rd_word = '0;
    case (addr)
      2'd0: if (!rx_empty) rd_word = {24'd0, rx_mem[rx_rd_ptr_reg]};
      2'd1: rd_word = status_word;
      2'd2: rd_word = {30'd0, irq_tx_en_reg, irq_rx_en_reg};
      2'd3: rd_word = 32'(tsc_reg);
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!tx_empty && !rs232out_busy) state_next = SEND;
      SEND:    state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Storage arrays carry no reset; the pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= req_wd[7:0];
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= rs232in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr_reg   <= '0;
      tx_rd_ptr_reg   <= '0;
      rx_wr_ptr_reg   <= '0;
      rx_rd_ptr_reg   <= '0;
      tx_count_reg    <= '0;
      rx_count_reg    <= '0;
      tsc_reg         <= '0;
      rx_overrun_reg  <= 1'b0;
      tx_overflow_reg <= 1'b0;
      irq_rx_en_reg   <= 1'b0;
      irq_tx_en_reg   <= 1'b0;
      res_rd_reg      <= '0;
      out_d_reg       <= '0;
      irq_reg         <= 1'b0;
      state_reg       <= IDLE;
    end else begin
      tsc_reg      <= tsc_reg + TSC_ONE;
      state_reg    <= state_next;
      tx_count_reg <= tx_count_next;
      rx_count_reg <= rx_count_next;
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + TX_PTR_ONE;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + TX_PTR_ONE;
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + RX_PTR_ONE;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + RX_PTR_ONE;
      // Fetch the head on the way into SEND so it is presented during the strobe.
      if (state_reg == IDLE && state_next == SEND)
        out_d_reg <= tx_mem[tx_rd_ptr_reg];
      if (ctrl_wr) begin
        irq_rx_en_reg <= req_wd[0];
        irq_tx_en_reg <= req_wd[1];
      end
      rx_overrun_reg  <= (rx_overrun_reg  && !sticky_clr) || rx_overrun_set;
      tx_overflow_reg <= (tx_overflow_reg && !sticky_clr) || tx_overflow_set;
      res_rd_reg      <= req_r ? rd_word : 32'd0;
      irq_reg         <= (irq_rx_en_reg && !rx_empty) || (irq_tx_en_reg && tx_empty);
    end
  end

  assign res_rd     = res_rd_reg;
  assign res_hold   = 1'b0;
  assign rs232out_w = (state_reg == SEND);
  assign rs232out_d = out_d_reg;
  assign irq        = irq_reg;

endmodule

// File: tb/tb_rs232_fifo_periph.sv
// Self-checking bench for rs232_fifo_periph with 4-entry FIFOs: register table,
// TX drain scoreboard, RX overrun/simultaneous push-pop, IRQ and mid-drain reset.
module tb_rs232_fifo_periph;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] req_a = '0;
  logic        req_r = 1'b0;
  logic        req_w = 1'b0;
  logic [31:0] req_wd = '0;
  logic [31:0] res_rd;
  logic        res_hold;
  logic        rs232in_attention = 1'b0;
  logic [7:0]  rs232in_data = '0;
  logic        rs232out_busy = 1'b0;
  logic        rs232out_w;
  logic [7:0]  rs232out_d;
  logic        irq;

  rs232_fifo_periph #(
    .TX_DEPTH_LOG2(2),
    .RX_DEPTH_LOG2(2),
    .TSC_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_a(req_a),
    .req_r(req_r),
    .req_w(req_w),
    .req_wd(req_wd),
    .res_rd(res_rd),
    .res_hold(res_hold),
    .rs232in_attention(rs232in_attention),
    .rs232in_data(rs232in_data),
    .rs232out_busy(rs232out_busy),
    .rs232out_w(rs232out_w),
    .rs232out_d(rs232out_d),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int last_w_cyc = -100;
  bit no_tx = 1'b0;

  logic [7:0]  tx_exp [$];
  logic [31:0] rd_exp [$];

  typedef struct {
    logic        wr_en;
    logic [31:0] wr_a;
    logic [31:0] wr_d;
    logic [31:0] rd_a;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // TX monitor: every strobe must match the oldest accepted byte, spaced >= 3 cycles.
  always @(negedge clk) begin
    if (no_tx)
      check("no_tx_pulse", 32'(rs232out_w), 32'd0);
    else if (rs232out_w === 1'b1) begin
      check("tx_pending", 32'(tx_exp.size() != 0), 32'd1);
      check("tx_spacing", 32'((cyc - last_w_cyc) >= 3), 32'd1);
      if (tx_exp.size() != 0) begin
        logic [7:0] e;
        e = tx_exp.pop_front();
        check("tx_byte", 32'(rs232out_d), 32'(e));
        $display("[TB] tx byte 0x%02h at cycle %0d", rs232out_d, cyc);
      end
      last_w_cyc = cyc;
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    req_a = a; req_wd = d; req_w = 1'b1;
    @(posedge clk); #1;
    req_w = 1'b0;
    $display("[TB] write 0x%01h <= 0x%08h", a, d);
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] e;
    rd_exp.push_back(exp);
    req_a = a; req_r = 1'b1;
    @(posedge clk); #1;
    req_r = 1'b0;
    e = rd_exp.pop_front();
    $display("[TB] read 0x%01h -> 0x%08h (%s)", a, res_rd, name);
    check(name, res_rd, e);
  endtask

  task automatic attention(input logic [7:0] b);
    rs232in_attention = 1'b1; rs232in_data = b;
    @(posedge clk); #1;
    rs232in_attention = 1'b0;
    $display("[TB] rx byte 0x%02h", b);
  endtask

  task automatic tx_write(input logic [7:0] b, input bit accepted);
    if (accepted) tx_exp.push_back(b);
    bus_write(32'h0, {24'd0, b});
  endtask

  task automatic wait_tx_drain(input string name);
    int n;
    n = 0;
    while (tx_exp.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(tx_exp.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] t1, t2;
    int n;

    tbl[0] = '{1'b0, 32'h0, 32'h0,        32'h4,  32'h0000_0006};
    tbl[1] = '{1'b0, 32'h0, 32'h0,        32'h0,  32'h0000_0000};
    tbl[2] = '{1'b1, 32'h8, 32'h3,        32'h8,  32'h0000_0003};
    tbl[3] = '{1'b1, 32'h8, 32'hFFFF_FFF9, 32'h8, 32'h0000_0001};
    tbl[4] = '{1'b1, 32'h4, 32'hFF,       32'h8,  32'h0000_0001};
    tbl[5] = '{1'b1, 32'hC, 32'h0,        32'h4,  32'h0000_0006};
    tbl[6] = '{1'b1, 32'h8, 32'h0,        32'h8,  32'h0000_0000};
    tbl[7] = '{1'b0, 32'h0, 32'h0,        32'h14, 32'h0000_0006};

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_rd", res_rd, 32'd0);
    check("rst_out_w", 32'(rs232out_w), 32'd0);
    check("rst_out_d", 32'(rs232out_d), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("res_hold", 32'(res_hold), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Register table
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr_en) bus_write(tbl[i].wr_a, tbl[i].wr_d);
      read_check($sformatf("tbl[%0d]", i), tbl[i].rd_a, tbl[i].exp);
    end
    @(posedge clk); #1;
    check("res_rd_idle", res_rd, 32'd0);

    // TSC: reads whose sampling edges are 11 cycles apart differ by 11
    read_check("tsc_first", 32'hC, 32'(dut.tsc_reg));
    t1 = res_rd;
    repeat (10) @(posedge clk);
    #1;
    req_a = 32'hC; req_r = 1'b1;
    @(posedge clk); #1;
    req_r = 1'b0;
    t2 = res_rd;
    check("tsc_delta", t2 - t1, 32'd11);

    // TX drain of three bytes
    tx_write(8'h41, 1'b1);
    tx_write(8'h42, 1'b1);
    tx_write(8'h43, 1'b1);
    wait_tx_drain("tx_drain_3");

    // TX overflow while PHY busy
    rs232out_busy = 1'b1;
    no_tx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) tx_write(8'(8'h10 + i), i < 4);
    read_check("tx_full_status", 32'h4, 32'h0004_0025);
    repeat (5) @(posedge clk);
    #1;
    bus_write(32'h8, 32'h4);
    read_check("tx_ovf_cleared", 32'h4, 32'h0004_0005);
    rs232out_busy = 1'b0;
    no_tx = 1'b0;
    wait_tx_drain("tx_drain_4");
    read_check("tx_idle_status", 32'h4, 32'h0000_0006);

    // RX overrun
    for (int i = 1; i <= 5; i++) attention(8'(i));
    read_check("rx_overrun_status", 32'h4, 32'h0000_041A);
    for (int i = 1; i <= 4; i++) read_check("rx_data", 32'h0, 32'(i));
    read_check("rx_data_empty", 32'h0, 32'h0);
    read_check("rx_empty_status", 32'h4, 32'h0000_0016);

    // RX full with simultaneous push and pop
    bus_write(32'h8, 32'h4);
    for (int i = 0; i < 4; i++) attention(8'(8'h21 + i));
    rd_exp.push_back(32'h21);
    req_a = 32'h0; req_r = 1'b1; rs232in_attention = 1'b1; rs232in_data = 8'h25;
    @(posedge clk); #1;
    req_r = 1'b0; rs232in_attention = 1'b0;
    $display("[TB] read+rx 0x25 on full -> 0x%08h", res_rd);
    check("rx_full_pushpop", res_rd, rd_exp.pop_front());
    read_check("rx_full_no_overrun", 32'h4, 32'h0000_040A);
    for (int i = 0; i < 4; i++) read_check("rx_after_pushpop", 32'h0, 32'(8'h22 + i));

    // Empty RX with simultaneous push and pop
    rd_exp.push_back(32'h0);
    req_a = 32'h0; req_r = 1'b1; rs232in_attention = 1'b1; rs232in_data = 8'h30;
    @(posedge clk); #1;
    req_r = 1'b0; rs232in_attention = 1'b0;
    $display("[TB] read+rx 0x30 on empty -> 0x%08h", res_rd);
    check("rx_empty_pushpop", res_rd, rd_exp.pop_front());
    read_check("rx_kept_byte", 32'h0, 32'h30);

    // IRQ on RX data
    bus_write(32'h8, 32'h1);
    check("irq_idle", 32'(irq), 32'd0);
    attention(8'h55);
    n = 0;
    while (irq !== 1'b1 && n < 2) begin
      @(posedge clk); #1;
      n++;
    end
    check("irq_rx_set", 32'(irq), 32'd1);
    read_check("irq_rx_data", 32'h0, 32'h55);
    @(posedge clk); #1;
    check("irq_rx_clear", 32'(irq), 32'd0);

    // Sticky set in the same cycle as the clear stays set
    for (int i = 0; i < 4; i++) attention(8'(8'h61 + i));
    req_a = 32'h8; req_wd = 32'h4; req_w = 1'b1;
    rs232in_attention = 1'b1; rs232in_data = 8'h65;
    @(posedge clk); #1;
    req_w = 1'b0; rs232in_attention = 1'b0;
    $display("[TB] clear + overrun in same cycle");
    read_check("sticky_set_wins", 32'h4, 32'h0000_041A);
    bus_write(32'h8, 32'h4);
    read_check("sticky_cleared", 32'h4, 32'h0000_040A);

    // Reset in the middle of a TX drain
    bus_write(32'h8, 32'h1);
    @(posedge clk); #1;
    check("irq_pending_rx", 32'(irq), 32'd1);
    tx_write(8'h71, 1'b1);
    tx_write(8'h72, 1'b1);
    tx_write(8'h73, 1'b1);
    n = 0;
    while (tx_exp.size() > 2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_tx_sent", 32'(tx_exp.size() <= 2), 32'd1);
    req_a = 32'h4; req_r = 1'b1;
    @(posedge clk); #2;
    req_r = 1'b0;
    rst_n = 1'b0;
    tx_exp.delete();
    no_tx = 1'b1;
    #1;
    $display("[TB] reset asserted mid-drain");
    check("midrst_res_rd", res_rd, 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    check("midrst_out_d", 32'(rs232out_d), 32'd0);
    check("midrst_out_w", 32'(rs232out_w), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    read_check("post_rst_status", 32'h4, 32'h0000_0006);
    read_check("post_rst_data", 32'h0, 32'h0);
    repeat (8) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
